// File: rtl/pc_trace_buf.sv
// pc_trace_buf: compressed PC history (one entry per PC change) in a circular buffer, frozen POST_HLT cycles after halt.
// Latency: capture lands on the sampling edge; rd_data/rd_valid appear one cycle after an honoured rd_req.
// Backpressure: none on capture (oldest entry overwritten when full); pops are ignored unless frozen and non-empty.
module pc_trace_buf #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int PC_W     = 16,
  parameter int POST_HLT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc,
  input  logic              hlt,
  input  logic              rd_req,
  output logic [PC_W-1:0]   rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              frozen,
  output logic              overflow
);

  // Post-halt countdown only needs to hold POST_HLT; keep at least one bit so
  // the POST_HLT==0 build still elaborates cleanly.
  localparam int POST_W = (POST_HLT < 2) ? 1 : $clog2(POST_HLT + 1);

  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];
  localparam logic [POST_W-1:0] POST_ONE = 1;
  localparam logic [POST_W-1:0] POST_INI = POST_HLT[POST_W-1:0];

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_POST    = 2'd1,
    ST_FROZEN  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [POST_W-1:0]   post_cnt;
  logic [POST_W-1:0]   post_cnt_nxt;

  logic [PC_W-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [PC_W-1:0]     last_pc;
  logic                first;
  logic                hlt_q;

  logic                hlt_edge;
  logic                capture_en;
  logic                do_wr;
  logic                do_rd;
  logic                full;

  // Capture runs in every state except FROZEN; a write happens only on the
  // first sample after reset or when the PC differs from the last one written,
  // so a held/stalled PC collapses to one entry.
  assign hlt_edge   = hlt && !hlt_q;
  assign capture_en = (state != ST_FROZEN);
  assign full       = (count == CNT_FULL);
  assign do_wr      = capture_en && (first || (pc != last_pc));
  assign do_rd      = (state == ST_FROZEN) && rd_req && (count != '0);

  // frozen comes straight from the state register, so it rises on the same
  // edge that performs the final capture.
  assign frozen = (state == ST_FROZEN);

  // FSM state and post-halt countdown registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_CAPTURE;
      post_cnt <= '0;
    end else begin
      state    <= state_nxt;
      post_cnt <= post_cnt_nxt;
    end
  end

  // Next-state: the halt edge starts a POST_HLT-cycle window (or freezes at
  // once when POST_HLT is zero); the cycle with post_cnt==1 is the last one
  // eligible for capture. FROZEN ignores further halt edges.
  always_comb begin
    state_nxt    = state;
    post_cnt_nxt = post_cnt;
    case (state)
      ST_CAPTURE: begin
        if (hlt_edge) begin
          if (POST_HLT == 0) begin
            state_nxt = ST_FROZEN;
          end else begin
            state_nxt    = ST_POST;
            post_cnt_nxt = POST_INI;
          end
        end
      end
      ST_POST: begin
        post_cnt_nxt = post_cnt - POST_ONE;
        if (post_cnt == POST_ONE) begin
          state_nxt = ST_FROZEN;
        end
      end
      ST_FROZEN: begin
        state_nxt = ST_FROZEN;
      end
      default: begin
        state_nxt = ST_CAPTURE;
      end
    endcase
  end

  // Halt edge detector and compression tracking (first flag, last written pc).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hlt_q   <= 1'b0;
      first   <= 1'b1;
      last_pc <= '0;
    end else begin
      hlt_q <= hlt;
      if (do_wr) begin
        first   <= 1'b0;
        last_pc <= pc;
      end
    end
  end

  // Trace storage; contents are meaningless after reset because count is 0.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= pc;
    end
  end

  // Pointers, occupancy and sticky overflow. A write into a full buffer
  // overwrites the oldest entry, so the read pointer is pushed along with it
  // and count stays at DEPTH. Writes and reads never coincide: writes need a
  // non-frozen state, reads need FROZEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (full) begin
          rd_ptr   <= rd_ptr + PTR_ONE;
          overflow <= 1'b1;
        end else begin
          count <= count + CNT_ONE;
        end
      end else if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        count  <= count - CNT_ONE;
      end
    end
  end

  // Read port: one-cycle valid pulse per honoured pop; data holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) begin
        rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_pc_trace_buf.sv
// Bench for pc_trace_buf: two instances (POST_HLT=0 and POST_HLT=4) share stimulus.
// Directed table + hand sequences with fixed expectations, then random traffic
// compared every cycle against a queue-based reference model.
module tb_pc_trace_buf;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int PC_W   = 16;

  logic              clk;
  logic              rst;
  logic [PC_W-1:0]   pc;
  logic              hlt;
  logic              rd_req;

  logic [PC_W-1:0]   rd_data0, rd_data4;
  logic              rd_valid0, rd_valid4;
  logic [ADDR_W:0]   count0, count4;
  logic              frozen0, frozen4;
  logic              overflow0, overflow4;

  int checks;
  int failures;

  pc_trace_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PC_W(PC_W), .POST_HLT(0)) dut0 (
    .clk(clk), .rst(rst), .pc(pc), .hlt(hlt), .rd_req(rd_req),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .count(count0),
    .frozen(frozen0), .overflow(overflow0)
  );

  pc_trace_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PC_W(PC_W), .POST_HLT(4)) dut4 (
    .clk(clk), .rst(rst), .pc(pc), .hlt(hlt), .rd_req(rd_req),
    .rd_data(rd_data4), .rd_valid(rd_valid4), .count(count4),
    .frozen(frozen4), .overflow(overflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (one per instance) ----------------
  logic [PC_W-1:0] q0[$];
  logic [PC_W-1:0] q1[$];
  bit              m_first [2];
  logic [PC_W-1:0] m_last  [2];
  bit              m_hq    [2];
  bit              m_frz   [2];
  int              m_post  [2];
  logic [PC_W-1:0] m_data  [2];
  bit              m_valid [2];
  bit              m_ovf   [2];

  function automatic int post_of(int k);
    return (k == 0) ? 0 : 4;
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void qpush(int k, logic [PC_W-1:0] v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endfunction

  function automatic logic [PC_W-1:0] qpop(int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_first[k] = 1'b1;
      m_last[k]  = '0;
      m_hq[k]    = 1'b0;
      m_frz[k]   = 1'b0;
      m_post[k]  = 0;
      m_data[k]  = '0;
      m_valid[k] = 1'b0;
      m_ovf[k]   = 1'b0;
    end
  endtask

  // Applies one clock edge's worth of behaviour using the inputs present at the edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit hedge;
      hedge      = hlt && !m_hq[k];
      m_valid[k] = 1'b0;
      if (!m_frz[k]) begin
        if (m_first[k] || pc != m_last[k]) begin
          qpush(k, pc);
          m_first[k] = 1'b0;
          m_last[k]  = pc;
          if (qsize(k) > DEPTH) begin
            void'(qpop(k));
            m_ovf[k] = 1'b1;
          end
        end
        if (m_post[k] > 0) begin
          m_post[k] = m_post[k] - 1;
          if (m_post[k] == 0) m_frz[k] = 1'b1;
        end else if (hedge) begin
          if (post_of(k) == 0) m_frz[k] = 1'b1;
          else                 m_post[k] = post_of(k);
        end
      end else if (rd_req && qsize(k) > 0) begin
        m_data[k]  = qpop(k);
        m_valid[k] = 1'b1;
      end
      m_hq[k] = hlt;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("m0.count",    32'(count0),    32'(qsize(0)));
    chk("m0.frozen",   32'(frozen0),   32'(m_frz[0]));
    chk("m0.valid",    32'(rd_valid0), 32'(m_valid[0]));
    chk("m0.data",     32'(rd_data0),  32'(m_data[0]));
    chk("m0.overflow", 32'(overflow0), 32'(m_ovf[0]));
    chk("m4.count",    32'(count4),    32'(qsize(1)));
    chk("m4.frozen",   32'(frozen4),   32'(m_frz[1]));
    chk("m4.valid",    32'(rd_valid4), 32'(m_valid[1]));
    chk("m4.data",     32'(rd_data4),  32'(m_data[1]));
    chk("m4.overflow", 32'(overflow4), 32'(m_ovf[1]));
  endtask

  task automatic drive(logic [PC_W-1:0] p, logic h, logic r);
    pc     = p;
    hlt    = h;
    rd_req = r;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
  endtask

  // Called between edges; the bench stays off the clock edges throughout.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  // ---------------- directed table (POST_HLT=0 instance) ----------------
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            hlt;
    logic            rd;
    logic [ADDR_W:0] cnt;
    logic            frz;
    logic            vld;
    logic [PC_W-1:0] dat;
  } vec_t;

  vec_t tbl [9];

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    drive('0, 1'b0, 1'b0);
    model_reset();

    tbl[0] = '{16'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{16'd1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{16'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 16'd0};
    tbl[3] = '{16'd3, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 16'd0};
    tbl[4] = '{16'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 16'd0};
    tbl[5] = '{16'd3, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 16'd1};
    tbl[6] = '{16'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 16'd2};
    tbl[7] = '{16'd3, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 16'd3};
    tbl[8] = '{16'd3, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 16'd3};

    #3;
    rst = 1'b0;
    // reset state
    chk("rst.count",    32'(count0),    32'd0);
    chk("rst.frozen",   32'(frozen0),   32'd0);
    chk("rst.valid",    32'(rd_valid0), 32'd0);
    chk("rst.data",     32'(rd_data0),  32'd0);
    chk("rst.overflow", 32'(overflow0), 32'd0);
    chk("rst.frozen4",  32'(frozen4),   32'd0);

    // Test 1: table-driven basic capture, freeze and drain
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].pc, tbl[i].hlt, tbl[i].rd);
      step();
      chk($sformatf("t1[%0d].count", i), 32'(count0),    32'(tbl[i].cnt));
      chk($sformatf("t1[%0d].frozen", i), 32'(frozen0),  32'(tbl[i].frz));
      chk($sformatf("t1[%0d].valid", i), 32'(rd_valid0), 32'(tbl[i].vld));
      chk($sformatf("t1[%0d].data", i),  32'(rd_data0),  32'(tbl[i].dat));
    end

    // Test 2: stalled PC compresses to a single entry
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(16'd5, 1'b0, 1'b0);
      step();
    end
    drive(16'd6, 1'b0, 1'b0); step();
    drive(16'd6, 1'b1, 1'b0); step();
    chk("t2.count",  32'(count0),  32'd2);
    chk("t2.frozen", 32'(frozen0), 32'd1);
    drive(16'd6, 1'b1, 1'b1); step();
    chk("t2.rd0", 32'(rd_data0), 32'd5);
    step();
    chk("t2.rd1", 32'(rd_data0), 32'd6);
    chk("t2.vld1", 32'(rd_valid0), 32'd1);

    // Test 3: overflow keeps the newest DEPTH entries
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(16'(i), 1'b0, 1'b0);
      step();
    end
    drive(16'd19, 1'b1, 1'b0); step();
    chk("t3.count",    32'(count0),    32'd16);
    chk("t3.overflow", 32'(overflow0), 32'd1);
    chk("t3.frozen",   32'(frozen0),   32'd1);
    for (int i = 0; i < 16; i++) begin
      drive(16'd19, 1'b1, 1'b1);
      step();
      chk($sformatf("t3.rd%0d", i), 32'(rd_data0), 32'(i + 4));
    end

    // Tests 4+5: post-halt window of 4 cycles, rd_req held high while capturing
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(16'(i), (i >= 10), (i <= 14));
      step();
      if (i <= 13) begin
        chk($sformatf("t4.frz%0d", i), 32'(frozen4),   32'd0);
        chk($sformatf("t5.vld%0d", i), 32'(rd_valid4), 32'd0);
        chk($sformatf("t5.cnt%0d", i), 32'(count4),    32'(i + 1));
      end else begin
        chk($sformatf("t4.frz%0d", i), 32'(frozen4), 32'd1);
        chk($sformatf("t4.cnt%0d", i), 32'(count4),  32'd15);
      end
    end
    for (int i = 0; i < 15; i++) begin
      drive(16'd99, 1'b1, 1'b1);
      step();
      chk($sformatf("t4.rd%0d", i), 32'(rd_data4), 32'(i));
    end
    step();
    chk("t4.empty_vld", 32'(rd_valid4), 32'd0);
    chk("t4.empty_cnt", 32'(count4),    32'd0);

    // Test 6: asynchronous reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(16'(i), (i == 4), 1'b0);
      step();
    end
    drive(16'd4, 1'b1, 1'b1); step(); step();
    chk("t6.pre_cnt", 32'(count0),    32'd3);
    chk("t6.pre_vld", 32'(rd_valid0), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6.async_cnt", 32'(count0),    32'd0);
    chk("t6.async_frz", 32'(frozen0),   32'd0);
    chk("t6.async_vld", 32'(rd_valid0), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    drive(16'd4, 1'b0, 1'b0); step();
    chk("t6.first_cnt", 32'(count0), 32'd1);

    // Random traffic against the model, with occasional resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      drive(16'($urandom_range(0, 7)), ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
